// File: rtl/analog_status_pkg.sv
// Shared address map, edge-mode encoding and APB helpers for the analog status monitor.
package analog_status_pkg;

    localparam logic [11:0] MASK_BASE    = 12'h000;
    localparam logic [11:0] PEND_BASE    = 12'h010;
    localparam logic [11:0] CTRL_ADDR    = 12'h020;
    localparam logic [11:0] SUMMARY_ADDR = 12'h024;
    localparam logic [11:0] RAW_ADDR     = 12'h028;
    localparam int unsigned CTRL_W       = 3;

    typedef enum logic [1:0] {
        EDGE_ANY  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_NONE = 2'd3
    } edge_mode_e;

    typedef enum logic [2:0] {
        SEL_ERR,
        SEL_MASK,
        SEL_PEND,
        SEL_CTRL,
        SEL_SUM,
        SEL_RAW
    } reg_sel_e;

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/status_edge_detect.sv
// Per-word transition detector: remembers the previous status word and reports
// edges of the selected polarity. The first cycle after reset only primes.
module status_edge_detect
    import analog_status_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] status_i,
    input  edge_mode_e        mode_i,
    output logic [WORD_W-1:0] edges_o
);

    logic [WORD_W-1:0] prev_q;
    logic              prime_q;
    logic [WORD_W-1:0] rise;
    logic [WORD_W-1:0] fall;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= '0;
            prime_q <= 1'b0;
        end else begin
            prev_q  <= status_i;
            prime_q <= 1'b1;
        end
    end

    always_comb begin
        rise    = status_i & ~prev_q;
        fall    = ~status_i & prev_q;
        edges_o = '0;
        if (prime_q) begin
            unique case (mode_i)
                EDGE_ANY:  edges_o = rise | fall;
                EDGE_RISE: edges_o = rise;
                EDGE_FALL: edges_o = fall;
                EDGE_NONE: edges_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/analog_status_monitor.sv
// Analog status event monitor: masked sticky edge flags per status word, level
// interrupt, and a registered two-cycle APB slave for configuration and W1C.
module analog_status_monitor
    import analog_status_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned WORD_W    = 32
) (
    input  logic                        clk_in,
    input  logic                        reset_n,
    input  logic [11:0]                 PADDR,
    input  logic                        PENABLE,
    input  logic                        PSEL,
    input  logic [3:0]                  PSTRB,
    input  logic [31:0]                 PWDATA,
    input  logic                        PWRITE,
    output logic [31:0]                 PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERR,
    input  logic [NUM_WORDS*WORD_W-1:0] status_i,
    output logic                        irq_o
);

    logic [WORD_W-1:0] mask_q [NUM_WORDS];
    logic [WORD_W-1:0] mask_d [NUM_WORDS];
    logic [WORD_W-1:0] pend_q [NUM_WORDS];
    logic [WORD_W-1:0] pend_d [NUM_WORDS];
    logic [WORD_W-1:0] edges  [NUM_WORDS];
    logic [WORD_W-1:0] status_w [NUM_WORDS];
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              irq_q, irq_d;

    logic [NUM_WORDS-1:0] summary;
    logic [NUM_WORDS-1:0] raw;
    logic [1:0]           widx;
    reg_sel_e             sel;
    logic                 access;
    logic                 err;
    logic                 wr;
    logic [31:0]          bm;
    logic [WORD_W-1:0]    w1c;
    logic [31:0]          rdata;
    logic                 unused_penable;

    // PENABLE plays no part: the handshake is keyed off PSEL alone.
    assign unused_penable = PENABLE;

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
        assign status_w[g] = status_i[g*WORD_W +: WORD_W];

        status_edge_detect #(
            .WORD_W(WORD_W)
        ) u_edge (
            .clk_in  (clk_in),
            .reset_n (reset_n),
            .status_i(status_w[g]),
            .mode_i  (edge_mode_e'(ctrl_q[2:1])),
            .edges_o (edges[g])
        );
    end

    always_comb begin
        widx = PADDR[3:2];
        sel  = SEL_ERR;
        if (PADDR[1:0] == 2'b00) begin
            if (PADDR[11:4] == MASK_BASE[11:4])
                sel = (32'(widx) < NUM_WORDS) ? SEL_MASK : SEL_ERR;
            else if (PADDR[11:4] == PEND_BASE[11:4])
                sel = (32'(widx) < NUM_WORDS) ? SEL_PEND : SEL_ERR;
            else if (PADDR == CTRL_ADDR)
                sel = SEL_CTRL;
            else if (PADDR == SUMMARY_ADDR)
                sel = SEL_SUM;
            else if (PADDR == RAW_ADDR)
                sel = SEL_RAW;
        end
    end

    always_comb begin
        // A transfer is accepted only on the first PSEL cycle; the ready cycle never re-accepts.
        access    = PSEL & ~pready_q;
        err       = (sel == SEL_ERR) | (PWRITE & ((sel == SEL_SUM) | (sel == SEL_RAW)));
        wr        = access & PWRITE & ~err;
        bm        = byte_mask(PSTRB);
        mask_d    = mask_q;
        ctrl_d    = ctrl_q;
        prdata_d  = prdata_q;
        pready_d  = access;
        pslverr_d = access & err;
        summary   = '0;
        raw       = '0;
        rdata     = '0;

        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            w1c = '0;
            if (wr && sel == SEL_PEND && 32'(widx) == i)
                w1c = WORD_W'(PWDATA & bm);
            // Set wins: a same-cycle event re-asserts a bit being cleared.
            pend_d[i] = (pend_q[i] & ~w1c) | (edges[i] & mask_q[i]);
            if (wr && sel == SEL_MASK && 32'(widx) == i)
                mask_d[i] = (mask_q[i] & ~WORD_W'(bm)) | WORD_W'(PWDATA & bm);
            summary[i] = |pend_q[i];
            raw[i]     = |(status_w[i] & mask_q[i]);
            if (32'(widx) == i) begin
                if (sel == SEL_MASK) rdata = 32'(mask_q[i]);
                if (sel == SEL_PEND) rdata = 32'(pend_q[i]);
            end
        end

        if (wr && sel == SEL_CTRL && PSTRB[0])
            ctrl_d = PWDATA[CTRL_W-1:0];

        if (sel == SEL_CTRL) rdata = 32'(ctrl_q);
        if (sel == SEL_SUM)  rdata = 32'(summary);
        if (sel == SEL_RAW)  rdata = 32'(raw);

        if (access && !err && !PWRITE)
            prdata_d = rdata;

        irq_d = ctrl_q[0] & (|summary);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                mask_q[i] <= '0;
                pend_q[i] <= '0;
            end
            ctrl_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            ctrl_q    <= ctrl_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_analog_status_monitor.sv
// Directed bench for analog_status_monitor: priming, edge modes, W1C race,
// APB error responses, byte strobes and asynchronous reset mid-transfer.
module tb_analog_status_monitor;

    logic         clk_in = 1'b0;
    logic         reset_n;
    logic [11:0]  PADDR;
    logic         PENABLE;
    logic         PSEL;
    logic [3:0]   PSTRB;
    logic [31:0]  PWDATA;
    logic         PWRITE;
    logic [31:0]  PRDATA;
    logic         PREADY;
    logic         PSLVERR;
    logic [127:0] status;
    logic         irq_o;

    int total = 0;
    int bad   = 0;

    analog_status_monitor #(
        .NUM_WORDS(4),
        .WORD_W   (32)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .PADDR   (PADDR),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PSTRB   (PSTRB),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .status_i(status),
        .irq_o   (irq_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_word(input int n, input logic [31:0] v);
        status[n*32 +: 32] = v;
    endtask

    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rd, output logic err);
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        PSTRB   = strb;
        tick();
        check("pready_hi", 32'(PREADY), 32'd1);
        rd      = PRDATA;
        err     = PSLVERR;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        tick();
        check("pready_lo", 32'(PREADY), 32'd0);
    endtask

    task automatic wr_reg(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, addr, data, strb, rd, err);
        check("wr_slverr", 32'(err), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb(1'b0, addr, 32'd0, 4'h0, rd, err);
        check({tag, "_slverr"}, 32'(err), 32'd0);
        check(tag, rd, exp);
    endtask

    task automatic err_chk(input string tag, input logic wr, input logic [11:0] addr);
        logic [31:0] rd;
        logic        err;
        apb(wr, addr, 32'hFFFF_FFFF, 4'hF, rd, err);
        check(tag, 32'(err), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;
        status  = '0;
        set_word(0, 32'hFFFF_FFFF);

        // Reset state
        tick();
        tick();
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        #3 reset_n = 1'b1;

        // 1: status already high at reset release is not an event
        tick();
        tick();
        rd_chk("prime_pend0", 12'h010, 32'h0);
        check("prime_irq", 32'(irq_o), 32'd0);

        // 2: any-edge mode, single rise on word 0
        set_word(0, 32'h0);
        tick();
        tick();
        wr_reg(12'h000, 32'h1, 4'hF);
        wr_reg(12'h020, 32'h1, 4'hF);
        set_word(0, 32'h1);
        tick();
        check("irq_lag", 32'(irq_o), 32'd0);
        tick();
        check("irq_set", 32'(irq_o), 32'd1);
        rd_chk("pend0", 12'h010, 32'h1);
        rd_chk("summary0", 12'h024, 32'h1);
        rd_chk("raw0", 12'h028, 32'h1);

        // 3: rise-only mode ignores the fall on word 2
        set_word(2, 32'h20);
        tick();
        wr_reg(12'h008, 32'h20, 4'hF);
        wr_reg(12'h020, 32'h3, 4'hF);
        set_word(2, 32'h0);
        tick();
        tick();
        rd_chk("pend2_fall", 12'h018, 32'h0);
        set_word(2, 32'h20);
        tick();
        rd_chk("pend2_rise", 12'h018, 32'h20);
        rd_chk("summary02", 12'h024, 32'h5);
        rd_chk("raw02", 12'h028, 32'h5);

        // 4: W1C colliding with a new event keeps the flag
        wr_reg(12'h010, 32'h1, 4'hF);
        rd_chk("pend0_clr", 12'h010, 32'h0);
        check("irq_hold2", 32'(irq_o), 32'd1);
        set_word(2, 32'h0);
        tick();
        set_word(2, 32'h20);
        wr_reg(12'h018, 32'h20, 4'hF);
        rd_chk("pend2_race", 12'h018, 32'h20);
        check("irq_race", 32'(irq_o), 32'd1);
        wr_reg(12'h018, 32'h20, 4'hF);
        check("irq_clr", 32'(irq_o), 32'd0);
        rd_chk("summary_clr", 12'h024, 32'h0);

        // fall-only mode
        wr_reg(12'h020, 32'h5, 4'hF);
        set_word(2, 32'h0);
        tick();
        rd_chk("pend2_fallmode", 12'h018, 32'h20);
        wr_reg(12'h018, 32'h20, 4'hF);
        rd_chk("pend2_clr2", 12'h018, 32'h0);

        // 5: error responses, PREADY drops even with PSEL held
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 12'h024;
        PWDATA  = 32'hFFFF_FFFF;
        PSTRB   = 4'hF;
        tick();
        check("err_pready", 32'(PREADY), 32'd1);
        check("err_slverr", 32'(PSLVERR), 32'd1);
        tick();
        check("held_pready", 32'(PREADY), 32'd0);
        check("held_slverr", 32'(PSLVERR), 32'd0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        tick();
        err_chk("err_rd40", 1'b0, 12'h040);
        err_chk("err_unaligned_wr", 1'b1, 12'h022);
        err_chk("err_unaligned_rd", 1'b0, 12'h002);
        err_chk("err_wr_raw", 1'b1, 12'h028);
        rd_chk("ctrl_kept", 12'h020, 32'h5);
        rd_chk("summary_kept", 12'h024, 32'h0);

        // 6: byte strobes, then reset in the middle of a transfer
        wr_reg(12'h004, 32'hAABB_CCDD, 4'h2);
        rd_chk("mask1_strb", 12'h004, 32'h0000_CC00);
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b0;
        PADDR   = 12'h004;
        tick();
        check("mid_pready", 32'(PREADY), 32'd1);
        check("mid_prdata", PRDATA, 32'h0000_CC00);
        PWRITE  = 1'b1;
        PWDATA  = 32'hFFFF_FFFF;
        PSTRB   = 4'hF;
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_pready", 32'(PREADY), 32'd0);
        check("rst_mid_prdata", PRDATA, 32'd0);
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        tick();
        #3 reset_n = 1'b1;
        tick();
        tick();
        rd_chk("mask1_rst", 12'h004, 32'h0);
        rd_chk("ctrl_rst", 12'h020, 32'h0);
        check("irq_rst", 32'(irq_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
